// File: rtl/rs232_loopback.sv
// ----------------------------------------------------------------------------
// rs232_loopback
//
// Purpose:
//   RS-232 (UART) echo block. Receives 8N1 frames on rx and retransmits every
//   correctly framed byte on tx. The path is a receiver, a one-byte holding
//   buffer and a transmitter, all in the clk domain.
//
// Ports (top level):
//   clk   in   1  system clock, rising edge
//   rstn  in   1  asynchronous active-low reset
//   rx    in   1  serial input, asynchronous to clk, idle high
//   tx    out  1  serial output, registered, idle high
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1), no parity.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// rs232_loopback_rx
//
// Purpose:
//   8N1 receiver. Synchronises rx, detects the start edge, samples each bit
//   at its centre and pulses rx_valid for one clock per good frame.
//
// Ports:
//   clk       in   1  system clock
//   rstn      in   1  asynchronous active-low reset
//   rx        in   1  raw serial input
//   rx_valid  out  1  one-clock pulse: rx_data holds a correctly framed byte
//   rx_data   out  8  received byte, valid while rx_valid is high
// ----------------------------------------------------------------------------
module rs232_loopback_rx #(
    parameter int BIT_CYCLES = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_fall;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Two flops resolve metastability; the third remembers the previous
    // synchronised level for edge detection.
    // NOTE: the chain resets to 1 (the idle line level), not 0, so that a
    // line that is idle at reset release does not look like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its predecessor, which is what forms a shift chain.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end

                // Re-check the line half a bit after the edge; a high level
                // there means the edge was a glitch.
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= ST_IDLE;
                        end else begin
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // From the start-bit centre, every full bit period lands on
                // the next bit centre. Shifting in from the top leaves the
                // first (LSB) bit at position 0 after eight samples.
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A low stop bit is a framing error: the byte is dropped.
                // Returning to IDLE at the stop-bit centre leaves half a bit
                // to catch the next start edge of a back-to-back frame.
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_data = shift;

endmodule

// ----------------------------------------------------------------------------
// rs232_loopback_tx
//
// Purpose:
//   8N1 transmitter. When idle and a byte is pending, takes it and sends
//   start, eight data bits LSB first and stop, each for BIT_CYCLES clocks.
//
// Ports:
//   clk       in   1  system clock
//   rstn      in   1  asynchronous active-low reset
//   pending   in   1  holding buffer has a byte
//   pend_data in   8  byte in the holding buffer
//   take      out  1  byte is taken this clock (buffer must clear)
//   tx        out  1  registered serial output, idle high
// ----------------------------------------------------------------------------
module rs232_loopback_tx #(
    parameter int BIT_CYCLES = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pending,
    input  logic [7:0] pend_data,
    output logic       take,
    output logic       tx
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign take = (state == ST_IDLE) && pending;

    // tx is set in the same edge that changes state, so the line level is a
    // flop output and never glitches on state decoding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        shift <= pend_data;
                        cnt   <= '0;
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // shift[0] is the bit on the line; shift[1] is the next one.
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b1, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// ----------------------------------------------------------------------------
// rs232_loopback (top)
//
// Ports:
//   clk   in   1  system clock
//   rstn  in   1  asynchronous active-low reset
//   rx    in   1  serial input, idle high
//   tx    out  1  serial output, idle high
// ----------------------------------------------------------------------------
module rs232_loopback #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic tx
);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       buf_full;
    logic [7:0] buf_data;
    logic       take;

    rs232_loopback_rx #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    // One-byte holding buffer. A new byte always wins: if it arrives while a
    // byte is still pending it overwrites it, and if it arrives in the same
    // clock the transmitter takes the old byte, full stays set for the new one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            if (rx_valid) begin
                buf_data <= rx_data;
                buf_full <= 1'b1;
            end else if (take) begin
                buf_full <= 1'b0;
            end
        end
    end

    rs232_loopback_tx #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx (
        .clk       (clk),
        .rstn      (rstn),
        .pending   (buf_full),
        .pend_data (buf_data),
        .take      (take),
        .tx        (tx)
    );

endmodule

// File: tb/tb_rs232_loopback.sv
// ----------------------------------------------------------------------------
// tb_rs232_loopback
//
// Drives 8N1 frames into rs232_loopback at a short bit period and decodes the
// echoed frames on tx. A queue holds the bytes that must come back, each with
// the earliest clock its start bit may appear at.
// ----------------------------------------------------------------------------
module tb_rs232_loopback;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;   // clocks per bit
    localparam int HALF     = B / 2;
    localparam int TOL      = 2;                 // start-time tolerance, clocks

    typedef struct {
        logic [7:0] data;
        int         ready;   // cycle the start bit is due if tx is idle
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic rx   = 1'b1;
    logic tx;

    int   cyc        = 0;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   last_start = -100000;
    exp_t exp_q[$];

    rs232_loopback #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Line level of bit k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic bit_at(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    // Called on a falling clock edge. The echo of a good frame is due at the
    // stop-bit centre (9.5 bits) plus 3 clocks to rx_valid, plus 2 clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit echo);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop_bit, d, 1'b0};
        if (echo) begin
            e.data  = d;
            e.ready = cyc + HALF + 9 * B + 5;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic send_idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic count_tx_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 40 * B) begin
            @(negedge clk);
            t++;
        end
        repeat (11 * B + 4) @(negedge clk);
        check({tag, "_all_echoed"}, exp_q.size(), 0);
        check({tag, "_tx_idle"}, tx, 1'b1);
    endtask

    // tx decoder: every frame must be expected, start on time, carry the
    // right byte and hold each bit level for exactly B clocks.
    initial begin : tx_monitor
        exp_t       e;
        int         start;
        int         exp_start;
        int         shape_err;
        logic [7:0] got;
        bit         aborted;
        bit         have;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx === 1'b0) begin
                start = cyc;
                have  = (exp_q.size() != 0);
                check("frame_expected", 32'(have), 1);
                e.data  = 8'h00;
                e.ready = 0;
                if (have) begin
                    e = exp_q.pop_front();
                    exp_start = (e.ready > last_start + 10 * B + 1) ? e.ready
                                                                    : last_start + 10 * B + 1;
                    last_start = exp_start;
                    check_range("start_time", start, exp_start - TOL, exp_start + TOL);
                end
                shape_err = 0;
                got       = 8'h00;
                aborted   = 1'b0;
                for (int i = 0; i < 10 * B; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rstn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== bit_at(e.data, i / B)) shape_err++;
                    if ((i % B) == HALF && (i / B) >= 1 && (i / B) <= 8) got[i/B-1] = tx;
                end
                if (!aborted && have) begin
                    check("tx_data", got, e.data);
                    check("tx_bit_shape", shape_err, 0);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] d;
        bit         bad;
        int         gap;
        int         lows;
        int         t;

        // Reset with rx low: release looks like a start edge, but rx is high
        // by the half-bit check, so it must be rejected.
        #1;
        rx   = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("reset_tx_high", tx, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        count_tx_low(12 * B, lows);
        check("reset_no_frame", lows, 0);

        // Back-to-back 0x00..0x07.
        for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b1);
        drain("echo_seq");

        // Alternating patterns with an idle gap.
        send_frame(8'hA5, 1'b1, 1'b1);
        send_idle(3 * B);
        send_frame(8'h5A, 1'b1, 1'b1);
        drain("pattern");

        // Framing error is dropped; the next good frame is echoed.
        send_frame(8'h3C, 1'b0, 1'b0);
        send_idle(2 * B);
        send_frame(8'h81, 1'b1, 1'b1);
        drain("framing");

        // Short low pulse must not start a frame.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        count_tx_low(12 * B, lows);
        check("glitch_no_frame", lows, 0);

        // Reset during data bit 3 of an echo of 0xF7 (bit 3 low).
        send_frame(8'hF7, 1'b1, 1'b1);
        t = 0;
        while (tx !== 1'b1 && t < 2 * B) begin   // wait for start bit to end
            @(negedge clk);
            t++;
        end
        repeat (3 * B + HALF) @(negedge clk);
        check("pre_reset_bit3_low", tx, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_async_tx_high", tx, 1'b1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        send_idle(2 * B);
        send_frame(8'h55, 1'b1, 1'b1);
        drain("after_reset");

        // Random bytes, some with framing errors, random gaps. A bad frame
        // leaves the line low through its stop bit, so it needs an idle gap
        // before the next start edge can be seen.
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad, !bad);
            gap = bad ? B + $urandom_range(0, B) : ($urandom_range(0, 1) * $urandom_range(0, B));
            send_idle(gap);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
